control_sequencer: RTL and testbench



---
 rtl/control_pkg.sv | 26 ++
 rtl/reg_select_decoder.sv | 10 +
 rtl/control_sequencer.sv | 117 +++++++++++
 tb/tb_control_sequencer.sv | 113 +++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: opcodes, IR field positions and sequencer state encodings
package control_pkg;
  typedef enum logic [3:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NOP = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  function automatic logic is_alu(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  endfunction
  function automatic logic is_md(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction
endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: 4-bit register index to one-hot select with enable
module reg_select_decoder #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] sel
);
  assign sel = en ? NUM_REGS'(1) << idx : '0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute sequencer driving phase-1 datapath strobes
module control_sequencer
  import control_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                pc_out,
  output logic                mar_in,
  output logic                inc_pc,
  output logic                mdr_read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                zlo_in,
  output logic                zhi_in,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic                lo_in,
  output logic                hi_in,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [4:0]          alu_op,
  output logic [3:0]          state,
  output logic                halted,
  output logic                illegal_op,
  output logic                bus_err
);
  localparam int CW = $clog2(WAIT_MAX) + 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);
  state_t cur, nxt;
  logic [CW-1:0] cnt;
  logic [4:0] op;
  logic [3:0] ra, rb, rc, out_idx;
  logic alu, md, timeout, bad_op, in_en, out_en, unused_ir;
  state_t done;
  assign op = ir[OP_MSB:OP_LSB];
  assign ra = ir[RA_MSB:RA_LSB];
  assign rb = ir[RB_MSB:RB_LSB];
  assign rc = ir[RC_MSB:RC_LSB];
  assign unused_ir = ^ir[RC_LSB-1:0];
  assign alu = is_alu(op);
  assign md = is_md(op);
  assign timeout = cur == S_T1 && !mem_ready && cnt == LAST;
  assign bad_op = cur == S_T3 && !(alu || md || op == OP_NOP || op == OP_HALT);
  assign done = run ? S_T0 : S_IDLE;
  assign out_idx = cur == S_T3 ? (md ? ra : rb) : (md ? rb : rc);
  assign state = cur;
  assign halted = cur == S_HALT;
  always_ff @(posedge clock) begin
    if (clear) begin
      cur <= S_IDLE;
      cnt <= '0;
      illegal_op <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= cur == S_T1 ? cnt + 1'b1 : '0;
      if (timeout) bus_err <= 1'b1;
      if (bad_op) illegal_op <= 1'b1;
    end
  end
  always_comb begin
    nxt = cur;
    {pc_out, mar_in, inc_pc, mdr_read, mdr_in, mdr_out, ir_in, y_in} = '0;
    {zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in} = '0;
    {in_en, out_en} = '0;
    alu_op = '0;
    case (cur)
      S_IDLE: nxt = run ? S_T0 : S_IDLE;
      S_T0: begin
        {pc_out, mar_in, inc_pc, zlo_in} = '1;
        nxt = S_T1;
      end
      S_T1: begin
        {mdr_read, mdr_in} = '1;
        nxt = mem_ready ? S_T2 : timeout ? S_HALT : S_T1;
      end
      S_T2: begin
        {mdr_out, ir_in} = '1;
        nxt = S_T3;
      end
      S_T3: begin
        y_in = alu || md;
        out_en = alu || md;
        nxt = (alu || md) ? S_T4 : op == OP_NOP ? done : S_HALT;
      end
      S_T4: begin
        out_en = 1'b1;
        zlo_in = 1'b1;
        zhi_in = md;
        alu_op = op;
        nxt = S_T5;
      end
      S_T5: begin
        zlo_out = 1'b1;
        lo_in = md;
        in_en = !md;
        nxt = md ? S_T6 : done;
      end
      S_T6: begin
        {zhi_out, hi_in} = '1;
        nxt = done;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_in_sel (.idx(ra), .en(in_en), .sel(reg_in));
  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_out_sel (.idx(out_idx), .en(out_en), .sel(reg_out));
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed instruction sequences checked against a queue of expected output snapshots
module tb_control_sequencer;
  localparam logic [3:0] IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4;
  localparam logic [3:0] T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8;
  localparam logic [13:0] PCO = 14'h2000, MARI = 14'h1000, INCP = 14'h0800, MRD = 14'h0400;
  localparam logic [13:0] MDRI = 14'h0200, MDRO = 14'h0100, IRI = 14'h0080, YI = 14'h0040;
  localparam logic [13:0] ZLI = 14'h0020, ZHI = 14'h0010, ZLO = 14'h0008, ZHO = 14'h0004;
  localparam logic [13:0] LOI = 14'h0002, HII = 14'h0001;
  localparam logic [13:0] FETCH0 = PCO | MARI | INCP | ZLI;
  localparam logic [13:0] FETCH1 = MRD | MDRI;
  localparam logic [13:0] FETCH2 = MDRO | IRI;
  typedef struct {
    string       tag;
    logic [57:0] v;
  } exp_t;
  logic clock = 1'b0, clear, run, mem_ready;
  logic [31:0] ir;
  logic pc_out, mar_in, inc_pc, mdr_read, mdr_in, mdr_out, ir_in, y_in;
  logic zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in, halted, illegal_op, bus_err;
  logic [15:0] reg_in, reg_out;
  logic [4:0] alu_op;
  logic [3:0] state;
  logic [57:0] obs;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  control_sequencer #(.NUM_REGS(16), .WAIT_MAX(8)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .mdr_read(mdr_read), .mdr_in(mdr_in),
    .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .zlo_in(zlo_in), .zhi_in(zhi_in),
    .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in),
    .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op), .state(state),
    .halted(halted), .illegal_op(illegal_op), .bus_err(bus_err)
  );
  always #5 clock = ~clock;
  assign obs = {pc_out, mar_in, inc_pc, mdr_read, mdr_in, mdr_out, ir_in, y_in,
                zlo_in, zhi_in, zlo_out, zhi_out, lo_in, hi_in,
                reg_in, reg_out, alu_op, state, halted, illegal_op, bus_err};
  task automatic tick(input string tag, input logic c, r, m, input logic [3:0] st,
                      input logic [13:0] sbits, input logic [15:0] ri, ro,
                      input logic [4:0] op, input logic [2:0] fl);
    exp_t e;
    clear = c;
    run = r;
    mem_ready = m;
    e.tag = tag;
    e.v = {sbits, ri, ro, op, st, fl};
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    n_checks++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
  endtask
  initial begin
    ir = 32'h18918000;
    tick("reset", 1, 0, 0, IDLE, 0, 0, 0, 0, 0);
    tick("idle_hold", 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
    tick("add_t0", 0, 1, 0, T0, FETCH0, 0, 0, 0, 0);
    tick("add_t1", 0, 0, 0, T1, FETCH1, 0, 0, 0, 0);
    tick("add_t2", 0, 0, 1, T2, FETCH2, 0, 0, 0, 0);
    tick("add_t3", 0, 0, 0, T3, YI, 0, 16'h0004, 0, 0);
    tick("add_t4", 0, 0, 0, T4, ZLI, 0, 16'h0008, 5'b00011, 0);
    tick("add_t5", 0, 1, 0, T5, ZLO, 16'h0002, 0, 0, 0);
    tick("add_back_t0", 0, 1, 0, T0, FETCH0, 0, 0, 0, 0);
    ir = 32'h79300000;
    tick("div_t1", 0, 1, 0, T1, FETCH1, 0, 0, 0, 0);
    tick("div_t2", 0, 1, 1, T2, FETCH2, 0, 0, 0, 0);
    tick("div_t3", 0, 0, 0, T3, YI, 0, 16'h0004, 0, 0);
    tick("div_t4", 0, 0, 0, T4, ZLI | ZHI, 0, 16'h0040, 5'b01111, 0);
    tick("div_t5", 0, 0, 0, T5, ZLO | LOI, 0, 0, 0, 0);
    tick("div_t6", 0, 1, 0, T6, ZHO | HII, 0, 0, 0, 0);
    tick("div_back_t0", 0, 1, 0, T0, FETCH0, 0, 0, 0, 0);
    ir = 32'hD0000000;
    tick("slow_t1_1", 0, 1, 0, T1, FETCH1, 0, 0, 0, 0);
    for (int i = 2; i <= 4; i++) tick($sformatf("slow_t1_%0d", i), 0, 1, 0, T1, FETCH1, 0, 0, 0, 0);
    tick("slow_t2", 0, 1, 1, T2, FETCH2, 0, 0, 0, 0);
    tick("nop_t3", 0, 1, 0, T3, 0, 0, 0, 0, 0);
    tick("nop_idle", 0, 0, 0, IDLE, 0, 0, 0, 0, 0);
    tick("buserr_t0", 0, 1, 0, T0, FETCH0, 0, 0, 0, 0);
    tick("buserr_t1_1", 0, 1, 0, T1, FETCH1, 0, 0, 0, 0);
    for (int i = 2; i <= 8; i++) tick($sformatf("buserr_t1_%0d", i), 0, 1, 0, T1, FETCH1, 0, 0, 0, 0);
    tick("buserr_halt", 0, 1, 0, HALT, 0, 0, 0, 0, 3'b101);
    tick("buserr_clear", 1, 0, 0, IDLE, 0, 0, 0, 0, 0);
    ir = 32'hA8000000;
    tick("ill_t0", 0, 1, 0, T0, FETCH0, 0, 0, 0, 0);
    tick("ill_t1", 0, 1, 0, T1, FETCH1, 0, 0, 0, 0);
    tick("ill_t2", 0, 1, 1, T2, FETCH2, 0, 0, 0, 0);
    tick("ill_t3", 0, 1, 0, T3, 0, 0, 0, 0, 0);
    tick("ill_halt", 0, 1, 0, HALT, 0, 0, 0, 0, 3'b110);
    tick("ill_stay", 0, 1, 1, HALT, 0, 0, 0, 0, 3'b110);
    tick("ill_clear", 1, 1, 0, IDLE, 0, 0, 0, 0, 0);
    ir = 32'h70900000;
    tick("mul_t0", 0, 1, 0, T0, FETCH0, 0, 0, 0, 0);
    tick("mul_t1", 0, 1, 0, T1, FETCH1, 0, 0, 0, 0);
    tick("mul_t2", 0, 1, 1, T2, FETCH2, 0, 0, 0, 0);
    tick("mul_t3", 0, 1, 0, T3, YI, 0, 16'h0002, 0, 0);
    tick("mul_t4", 0, 1, 0, T4, ZLI | ZHI, 0, 16'h0004, 5'b01110, 0);
    tick("mul_abort", 1, 0, 0, IDLE, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick($sformatf("idle_run0_%0d", i), 0, 0, 1, IDLE, 0, 0, 0, 0, 0);
    ir = 32'hD8000000;
    tick("halt_t0", 0, 1, 0, T0, FETCH0, 0, 0, 0, 0);
    tick("halt_t1", 0, 1, 0, T1, FETCH1, 0, 0, 0, 0);
    tick("halt_t2", 0, 1, 1, T2, FETCH2, 0, 0, 0, 0);
    tick("halt_t3", 0, 1, 0, T3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick($sformatf("halt_hold_%0d", i), 0, 1, 1, HALT, 0, 0, 0, 0, 3'b100);
    tick("halt_clear", 1, 1, 0, IDLE, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
